d_input_conditioner: RTL and testbench
======================================

# d_input_conditioner

- Upstream feeder for the team's D flip-flop FSM. It takes a raw, asynchronous, possibly bouncing level input and produces the clean, clock-synchronous `d` that the flip-flop stage samples.
- It has three parts:
  - a synchroniser chain that resynchronises the input;
  - a counter-based debounce FSM that accepts a level only after it has been stable for a programmable number of cycles;
  - optional single-cycle edge pulses, so downstream logic does not need its own edge detector.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops (legal range 2..4).
- `STABLE_CYCLES`, default 4: consecutive synchronised cycles a new level must hold before it is accepted (legal range 1..65535).
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: width of the stability counter. Derived; never overridden.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: sole clock.
  - `reset`, in, 1: asynchronous, active-high.
- `din_raw`, in, 1: raw asynchronous input (switch or pin).
- `d`, out, 1: debounced, synchronous level. Feeds the flip-flop stage's `d`.
- `rise`, out, 1: one-cycle pulse in the cycle `d` goes 0→1.
- `fall`, out, 1: one-cycle pulse in the cycle `d` goes 1→0.
- `busy`, out, 1: high while a level change is pending (FSM in `PEND_HI` or `PEND_LO`).

## Operation
Reset:
- All synchroniser flops, the counter, `d`, `rise`, `fall` and `busy` clear to 0.
- The FSM goes to `STABLE_LO`.

Synchroniser:
- `din_raw` passes through `SYNC_STAGES` flops; the last flop output is `s`.
- Only `s` is used downstream of the chain.

FSM states and transitions (counter `cnt`):
- `STABLE_LO` (d=0):
  - if `s`=1, go to `PEND_HI` with `cnt`=1;
  - if `STABLE_CYCLES`=1, go instead directly to `STABLE_HI` and set `d`=1.
- `PEND_HI` (d=0, busy=1):
  - if `s`=0, return to `STABLE_LO` and clear `cnt` (glitch rejected);
  - else if `cnt`==`STABLE_CYCLES`-1, go to `STABLE_HI`, set `d`=1, clear `cnt`;
  - else increment `cnt`.
- `STABLE_HI` and `PEND_LO`: mirror images of the above, with polarity inverted.

Edge pulses:
- `rise` and `fall` are registered.
- Each is asserted for exactly the cycle in which the new `d` value is first visible.

Counter arithmetic:
- `cnt` is unsigned, `CNT_W` bits, and never exceeds `STABLE_CYCLES`-1.
- There is no wrap-around.

Simultaneous events:
- If `s` reverts on the same edge the counter would complete, the revert wins: no change to `d`, no pulse.

Reset mid-operation:
- An asynchronous reset in any state immediately forces the reset values above.
- A pending change is discarded.
- If `din_raw` is still high after reset is released, the block re-qualifies from `STABLE_LO`, with the full latency below.

Out-of-range parameters:
- Out-of-range parameter values are a `$error` at elaboration.

## Timing
Latency from a clean `din_raw` transition to `d`:
- `SYNC_STAGES` + `STABLE_CYCLES` rising edges.
- With the defaults this is 6 edges.

Pulse timing:
- `rise` and `fall` coincide with the `d` change, one cycle wide, never back-to-back.
- The minimum spacing between opposite pulses is `STABLE_CYCLES` cycles.

`busy`:
- Asserts one cycle after `s` first differs from `d`.
- Deasserts in the same cycle `d` updates or the glitch is rejected.

Glitch rejection:
- Any `s` excursion shorter than `STABLE_CYCLES` cycles produces no change on `d`.

## Configuration
Macro `D_INPUT_EDGE_PULSE_EN`:
- Defined: the `rise` and `fall` registers are built and behave as described above.
- Undefined:
  - `rise` and `fall` are tied to constant 0;
  - no edge registers are synthesised;
  - `d` and `busy` behaviour is unchanged.

## Structure
Shared package `d_input_pkg`:
- `typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} dic_state_t;`
- Legal parameter bounds: `DIC_SYNC_MIN`=2, `DIC_SYNC_MAX`=4, `DIC_STABLE_MAX`=65535.

Sub-module `sync_chain`:
- Parameterised by `SYNC_STAGES`.
- Ports: `clk`, `reset`, async in, sync out.
- Carries the synthesis attribute that keeps its flops adjacent, and is reused elsewhere.

Top level:
- The top holds the FSM, the counter and the pulse logic.

## Test plan
All scenarios use the defaults, `SYNC_STAGES`=2 and `STABLE_CYCLES`=4, unless stated.
1. Reset, then assert and hold `din_raw`=1 from edge 10 → `d`=1 and `rise`=1 at edge 16 only; `busy` is high from edge 13 to edge 15.
2. `din_raw`=1 for 3 cycles, then back to 0 → `d` stays 0; no `rise`; `busy` pulses and then clears.
3. From steady `d`=1, drop `din_raw` to 0 and hold → `d`=0 and `fall`=1 exactly 6 edges later; `rise` is never seen.
4. Assert `reset` mid-`PEND_HI` (cnt=2) with `din_raw` still 1 → immediately `d`=0, `busy`=0; after release, `d`=1 at 6 edges post-release.
5. Rebuild with `STABLE_CYCLES`=1 and without `D_INPUT_EDGE_PULSE_EN`; toggle `din_raw` every 5 cycles → `d` follows with 3-edge latency; `rise` and `fall` are constant 0.
6. Bouncing input: 5 random transitions within 3-cycle windows, then stable high → exactly one `rise` and one `d` transition; the assertion checks `cnt` never exceeds 3.

Source files
------------

// File: rtl/d_input_pkg.sv
// Shared types and parameter bounds for the D-input conditioner.
package d_input_pkg;

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} dic_state_t;

  localparam int DIC_SYNC_MIN   = 2;
  localparam int DIC_SYNC_MAX   = 4;
  localparam int DIC_STABLE_MAX = 65535;

  // Level presented on d for a given debounce state.
  function automatic logic dic_level(dic_state_t st);
    return (st == STABLE_HI) || (st == PEND_LO);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop resynchroniser for a single asynchronous bit; last flop drives sync_o.
module sync_chain
  import d_input_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  if (SYNC_STAGES < DIC_SYNC_MIN || SYNC_STAGES > DIC_SYNC_MAX) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end

  // Keep the chain flops adjacent so the first stage has maximum settling time.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/d_input_conditioner.sv
// Synchronise, debounce and edge-detect a raw level input for the D flip-flop stage.
// Edge pulses are built only when D_INPUT_EDGE_PULSE_EN is defined.
module d_input_conditioner
  import d_input_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic d,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > DIC_STABLE_MAX) begin : g_bad_stable
    $error("d_input_conditioner: STABLE_CYCLES=%0d out of range", STABLE_CYCLES);
  end
  if (SYNC_STAGES < DIC_SYNC_MIN || SYNC_STAGES > DIC_SYNC_MAX) begin : g_bad_sync
    $error("d_input_conditioner: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  dic_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(din_raw),
    .sync_o (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A revert of s always beats counter completion in the pending states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: if (s) begin
        if (STABLE_CYCLES == 1) state_d = STABLE_HI;
        else begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: if (!s) begin
        if (STABLE_CYCLES == 1) state_d = STABLE_LO;
        else begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    d    = dic_level(state_q);
    busy = (state_q == PEND_HI) || (state_q == PEND_LO);
  end

`ifdef D_INPUT_EDGE_PULSE_EN
  logic rise_q, fall_q;
  logic d_nxt;

  assign d_nxt = dic_level(state_d);

  // Registered alongside the state so each pulse lines up with the new d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= d_nxt & ~d;
      fall_q <= ~d_nxt & d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  a_cnt_range: assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_d_input_conditioner.sv
// Directed bench for d_input_conditioner: default build plus a STABLE_CYCLES=1 instance.
module tb_d_input_conditioner;

`ifdef D_INPUT_EDGE_PULSE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din1 = 1'b0;
  logic d, rise, fall, busy;
  logic d1, rise1, fall1, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_input_conditioner dut (
    .clk(clk), .reset(reset), .din_raw(din),
    .d(d), .rise(rise), .fall(fall), .busy(busy)
  );

  d_input_conditioner #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .din_raw(din1),
    .d(d1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    din   = 1'b0;
    din1  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({d, rise, fall, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_main got d/rise/fall/busy=%b exp=0000", {d, rise, fall, busy});
    end
    checks++;
    if ({d1, rise1, fall1, busy1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_s1 got d/rise/fall/busy=%b exp=0000", {d1, rise1, fall1, busy1});
    end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // din rises just after reference edge; d and rise expected 6 edges later.
  task automatic test_rise;
    logic [3:0] exp;
    din = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k >= 6), (EDGE_EN && k == 6), 1'b0, (k >= 3 && k <= 5)};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL rise_k%0d got d/rise/fall/busy=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_fall;
    logic [3:0] exp;
    din = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k < 6), 1'b0, (EDGE_EN && k == 6), (k >= 3 && k <= 5)};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL fall_k%0d got d/rise/fall/busy=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  // Three-cycle pulse: s reverts exactly when the counter would complete.
  task automatic test_glitch;
    logic [3:0] exp;
    din = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) din = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, (k >= 3 && k <= 5)};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL glitch_k%0d got d/rise/fall/busy=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp;
    din = 1'b1;
    repeat (4) tick();
    checks++;
    if ({d, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_pre got d/busy=%b exp=01", {d, busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({d, rise, fall, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_async got d/rise/fall/busy=%b exp=0000", {d, rise, fall, busy});
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = {(k >= 6), (EDGE_EN && k == 6), 1'b0, (k >= 3 && k <= 5)};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL rstmid_k%0d got d/rise/fall/busy=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  // STABLE_CYCLES=1: d follows din with a 3-edge latency, never pending.
  task automatic test_stable1;
    logic hist [0:40];
    logic ed, ep;
    logic [3:0] exp;
    hist[0] = 1'b0;
    din1 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      ed  = (k >= 3) ? hist[k-3] : 1'b0;
      ep  = (k >= 4) ? hist[k-4] : 1'b0;
      exp = {ed, (EDGE_EN && ed && !ep), (EDGE_EN && !ed && ep), 1'b0};
      checks++;
      if ({d1, rise1, fall1, busy1} !== exp) begin
        failures++;
        $display("FAIL stable1_k%0d got d/rise/fall/busy=%b exp=%b", k, {d1, rise1, fall1, busy1}, exp);
      end
      hist[k] = (((k / 5) % 2) == 1);
      din1 = hist[k];
    end
  endtask

  task automatic test_bounce;
    int dur [5] = '{2, 1, 3, 2, 20};
    int ntrans = 0;
    int nrise = 0;
    int nfall = 0;
    logic prev;
    din = 1'b0;
    repeat (10) tick();
    prev = d;
    for (int i = 0; i < 5; i++) begin
      din = ((i % 2) == 0);
      for (int j = 0; j < dur[i]; j++) begin
        tick();
        if (d !== prev) ntrans++;
        if (rise === 1'b1) nrise++;
        if (fall === 1'b1) nfall++;
        prev = d;
      end
    end
    checks++;
    if (ntrans != 1) begin
      failures++;
      $display("FAIL bounce_trans got=%0d exp=1", ntrans);
    end
    checks++;
    if (nrise != int'(EDGE_EN) || nfall != 0) begin
      failures++;
      $display("FAIL bounce_pulses got rise=%0d fall=%0d exp rise=%0d fall=0", nrise, nfall, int'(EDGE_EN));
    end
    checks++;
    if ({d, busy} !== 2'b10) begin
      failures++;
      $display("FAIL bounce_final got d/busy=%b exp=10", {d, busy});
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_reset_mid();
    test_stable1();
    test_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
